multiword_sub_sequencer: RTL
============================

Name: multiword_sub_sequencer

Overview:
- Streaming multi-precision subtract controller. It wraps the team's N-bit ripple borrow subtractor (ports a, b, Cin, y, Cout).
- Accepts one N-bit word pair per cycle, least-significant word first, and drives the subtractor combinationally.
- Chains the borrow between words of the same operand and registers each difference word with valid/ready handshakes on both sides.
- Computes A − B for operands of WORDS×N bits. Also reports the final borrow (A < B unsigned) and an all-zero flag.

Parameters:
- N, 16, word width; must match the subtractor instance.
- WORDS, 4, words per operand; must be ≥1. Counter width is clog2(WORDS), minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  word pair present
- in_ready  output  1  block can accept a word pair this cycle
- in_a  input  N  minuend word
- in_b  input  N  subtrahend word
- sub_a  output  N  to subtractor a; equals in_a
- sub_b  output  N  to subtractor b; equals in_b
- sub_cin  output  1  to subtractor Cin (borrow-in)
- sub_y  input  N  from subtractor y
- sub_cout  input  1  from subtractor Cout (borrow-out)
- out_valid  output  1  result word present
- out_ready  input  1  consumer accepts result word
- out_y  output  N  difference word
- out_last  output  1  out_y is the most-significant word of the operand
- out_borrow  output  1  final borrow; meaningful only when out_last=1, else 0
- out_zero  output  1  whole result equals zero; meaningful only when out_last=1, else 0

Behaviour:
- Reset (rst=1 at a clk edge) sets out_valid=0, out_y=0, out_last=0, out_borrow=0, out_zero=0, word count=0, borrow_q=0, zero_q=1. Reset mid-operand discards the partial operand; the next accepted word is treated as word 0.
- sub_a and sub_b are pure pass-through of in_a and in_b. sub_cin = 0 when count==0, else borrow_q; it is purely combinational.
- in_ready = ~out_valid | out_ready. This is a single register stage with no bubble under continuous out_ready=1.
- accept = in_valid & in_ready. On accept, at the next edge:
  - out_y ← sub_y; out_valid ← 1.
  - out_last ← (count==WORDS−1).
  - If not last: borrow_q ← sub_cout; zero_q ← zero_q & (sub_y==0); count ← count+1.
  - If last: out_borrow ← sub_cout; out_zero ← zero_q & (sub_y==0); count ← 0; borrow_q ← 0; zero_q ← 1.
  - For non-last words, out_borrow and out_zero are 0.
- When out_valid & out_ready with no accept, out_valid ← 0. All out_* hold their values while out_valid=1 and out_ready=0.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 word per cycle.
- Simultaneous output handoff and new accept in the same cycle: the new word replaces the old one and out_valid stays 1.
- in_a and in_b are ignored when in_valid=0. count and borrow_q change only on accept. Idle gaps between words of one operand are allowed.
- WORDS=1 case: every word is last, and sub_cin is always 0.
- Subtraction is unsigned modulo 2^(WORDS·N). A wrapped result is flagged by out_borrow=1.

Test Plan:
- Reset, N=16, WORDS=2: hold rst for 2 cycles, then release → out_valid=0, in_ready=1, sub_cin=0.
- Borrow chain: A=0x0001_0000, B=0x0000_0001, words sent back-to-back with out_ready=1 →
  - word 0: out_y=0xFFFF, out_last=0, and sub_cin=1 on the next word.
  - word 1: out_y=0x0000, out_last=1, out_borrow=0, out_zero=0.
- Negative wrap: A=0x0000_0000, B=0x0000_0001 → words 0xFFFF, 0xFFFF; out_borrow=1, out_zero=0.
- Equal operands: A=B=0x1234_5678 → words 0x0000, 0x0000; out_zero=1, out_borrow=0. The following operand starts with sub_cin=0.
- Backpressure: out_ready=0 for 3 cycles after the first result →
  - in_ready=0 and out_y holds 0xFFFF.
  - When out_ready rises, the next word is accepted that same cycle and no word is lost or duplicated.
- Mid-operand reset: accept word 0 of A=0x0001_0000, B=0x0000_0001, then assert rst → borrow_q=0. The next operand A=0x0000_0005, B=0x0000_0003 yields words 0x0002, 0x0000 with out_borrow=0.

Source files
------------

// File: rtl/multiword_sub_sequencer.sv
// multiword_sub_sequencer: streams word pairs LSW-first through an external subtractor, chaining borrow and registering results.
module multiword_sub_sequencer #(
  parameter int N = 16,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] sub_a,
  output logic [N-1:0] sub_b,
  output logic         sub_cin,
  input  logic [N-1:0] sub_y,
  input  logic         sub_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         out_last,
  output logic         out_borrow,
  output logic         out_zero
);
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_y_q, out_y_d;
  logic          out_last_q, out_last_d;
  logic          out_borrow_q, out_borrow_d;
  logic          out_zero_q, out_zero_d;
  logic [CW-1:0] count_q, count_d;
  logic          borrow_q, borrow_d;
  logic          zero_q, zero_d;
  logic          accept, last, y_zero;
  assign sub_a      = in_a;
  assign sub_b      = in_b;
  assign sub_cin    = (count_q == '0) ? 1'b0 : borrow_q;
  assign in_ready   = ~out_valid_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign last       = (count_q == LAST_CNT);
  assign y_zero     = (sub_y == '0);
  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_last   = out_last_q;
  assign out_borrow = out_borrow_q;
  assign out_zero   = out_zero_q;
  always_comb begin
    out_valid_d  = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_y_d      = accept ? sub_y : out_y_q;
    out_last_d   = accept ? last : out_last_q;
    out_borrow_d = accept ? (last & sub_cout) : out_borrow_q;
    out_zero_d   = accept ? (last & zero_q & y_zero) : out_zero_q;
    count_d      = accept ? (last ? '0 : count_q + 1'b1) : count_q;
    borrow_d     = accept ? (~last & sub_cout) : borrow_q;
    zero_d       = accept ? (last | (zero_q & y_zero)) : zero_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
      out_last_q   <= 1'b0;
      out_borrow_q <= 1'b0;
      out_zero_q   <= 1'b0;
      count_q      <= '0;
      borrow_q     <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      out_last_q   <= out_last_d;
      out_borrow_q <= out_borrow_d;
      out_zero_q   <= out_zero_d;
      count_q      <= count_d;
      borrow_q     <= borrow_d;
      zero_q       <= zero_d;
    end
  end
endmodule
